ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/rv32m_pkg.sv | 31 +++
 rtl/div_iter.sv | 80 ++++++++
 rtl/ex_muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// RV32M shared constants: FUNC3 encodings, mul/div FSM states
// and small opcode-class helpers.
package rv32m_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic is_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU) ||
           (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic is_sdiv(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, DIV_RADIX_BITS quotient bits
// per cycle, start/busy/done handshake with abort.
module div_iter #(
  parameter int XLEN           = 32,
  parameter int DIV_RADIX_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int ITER = XLEN / DIV_RADIX_BITS;
  localparam int CW   = $clog2(ITER + 1);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] rem_d, quo_d;
  logic [XLEN:0]   sh, diff;
  logic [CW-1:0]   cnt_q;

  // quo_q doubles as the dividend shift register
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    sh    = '0;
    diff  = '0;
    for (int i = 0; i < DIV_RADIX_BITS; i++) begin
      sh    = {rem_d, quo_d[XLEN-1]};
      quo_d = {quo_d[XLEN-2:0], 1'b0};
      diff  = sh - {1'b0, dvs_q};
      if (!diff[XLEN]) begin
        rem_d    = diff[XLEN-1:0];
        quo_d[0] = 1'b1;
      end else begin
        rem_d = sh[XLEN-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy  <= 1'b0;
        cnt_q <= '0;
      end else if (start) begin
        rem_q <= '0;
        quo_q <= dividend;
        dvs_q <= divisor;
        cnt_q <= CW'(ITER);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit: single-cycle multiply, iterative divide,
// special-case fixups and signed result correction.
import rv32m_pkg::*;

module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int DIV_RADIX_BITS = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] OP1,
  input  logic [XLEN-1:0] OP2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            BUSYWAIT,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state_q, state_d;

  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q, b_q, result_q;
  logic              accept, sdiv_in, fix_in, div_start;
  logic              div_busy, div_done;
  logic [XLEN-1:0]   abs_a, abs_b, uq, ur;
  logic              a_sgn, b_sgn, sdiv_q, rem_op;
  logic              neg_q, neg_r;
  logic [2*XLEN-1:0] ax, bx, prod;
  logic [XLEN-1:0]   mul_res, div_res, fix_res, res_d;

  assign accept = (state_q == ST_IDLE || state_q == ST_DONE)
                  && START && !FLUSH;

  assign sdiv_in = is_sdiv(FUNC3);
  assign fix_in  = (OP2 == '0) ||
                   (sdiv_in && OP1 == MIN_NEG && OP2 == '1);
  assign div_start = accept && is_div(FUNC3) && !fix_in;

  // divider starts on the accept edge, straight from the operands
  assign abs_a = (sdiv_in && OP1[XLEN-1]) ? -OP1 : OP1;
  assign abs_b = (sdiv_in && OP2[XLEN-1]) ? -OP2 : OP2;

  div_iter #(
    .XLEN           (XLEN),
    .DIV_RADIX_BITS (DIV_RADIX_BITS)
  ) u_div (
    .clk       (CLK),
    .rst_n     (RESET),
    .start     (div_start),
    .abort     (FLUSH),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (uq),
    .remainder (ur)
  );

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (f3_q)
      F3_MULH: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      F3_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase
  end

  // 2*XLEN extension makes the wrapped product exact
  assign ax   = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
  assign bx   = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
  assign prod = ax * bx;

  assign mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0]
                                    : prod[2*XLEN-1:XLEN];

  assign sdiv_q = is_sdiv(f3_q);
  assign rem_op = (f3_q == F3_REM) || (f3_q == F3_REMU);
  assign neg_q  = sdiv_q && (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign neg_r  = sdiv_q && a_q[XLEN-1];

  assign div_res = rem_op ? (neg_r ? -ur : ur)
                          : (neg_q ? -uq : uq);

  assign fix_res = (b_q == '0) ? (rem_op ? a_q : '1)
                               : (rem_op ? '0 : a_q);

  always_comb begin
    res_d = div_res;
    unique case (1'b1)
      (state_q == ST_MUL): res_d = mul_res;
      (state_q == ST_FIX): res_d = fix_res;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (!accept)               state_d = ST_IDLE;
        else if (!is_div(FUNC3))   state_d = ST_MUL;
        else if (fix_in)           state_d = ST_FIX;
        else                       state_d = ST_DIV;
      end
      ST_MUL, ST_FIX: state_d = ST_DONE;
      ST_DIV: begin
        if (div_done)       state_d = ST_DONE;
        else if (!div_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (FLUSH) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q <= FUNC3;
        a_q  <= OP1;
        b_q  <= OP2;
      end
      if (state_d == ST_DONE) result_q <= res_d;
    end
  end

  assign BUSY = (state_q == ST_MUL) || (state_q == ST_DIV) ||
                (state_q == ST_FIX);
  assign DONE     = (state_q == ST_DONE);
  assign BUSYWAIT = RESET && (START || BUSY) && !DONE;
  assign RESULT   = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomized checks of ex_muldiv_unit at
// XLEN=32 (radix 1 and 2) and XLEN=16 against an arithmetic model.
module tb_ex_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, go;
  logic [1:0]  sel;
  logic [2:0]  FUNC3;
  logic [31:0] OP1, OP2;
  logic        st0, st1, st2;
  logic        busy0, bw0, done0;
  logic        busy1, bw1, done1;
  logic        busy2, bw2, done2;
  logic [31:0] res0, res1;
  logic [15:0] res2;
  logic        cur_done;
  logic [31:0] cur_res;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 CLK = ~CLK;

  assign st0 = go && (sel == 2'd0);
  assign st1 = go && (sel == 2'd1);
  assign st2 = go && (sel == 2'd2);

  always_comb begin
    cur_done = done0;
    cur_res  = res0;
    if (sel == 2'd1) begin
      cur_done = done1;
      cur_res  = res1;
    end else if (sel == 2'd2) begin
      cur_done = done2;
      cur_res  = {16'h0, res2};
    end
  end

  ex_muldiv_unit #(.XLEN(32), .DIV_RADIX_BITS(1)) u_r1 (
    .CLK(CLK), .RESET(RESET), .START(st0), .FUNC3(FUNC3),
    .OP1(OP1), .OP2(OP2), .FLUSH(FLUSH), .BUSY(busy0),
    .BUSYWAIT(bw0), .DONE(done0), .RESULT(res0)
  );

  ex_muldiv_unit #(.XLEN(32), .DIV_RADIX_BITS(2)) u_r2 (
    .CLK(CLK), .RESET(RESET), .START(st1), .FUNC3(FUNC3),
    .OP1(OP1), .OP2(OP2), .FLUSH(FLUSH), .BUSY(busy1),
    .BUSYWAIT(bw1), .DONE(done1), .RESULT(res1)
  );

  ex_muldiv_unit #(.XLEN(16), .DIV_RADIX_BITS(2)) u_x16 (
    .CLK(CLK), .RESET(RESET), .START(st2), .FUNC3(FUNC3),
    .OP1(OP1[15:0]), .OP2(OP2[15:0]), .FLUSH(FLUSH),
    .BUSY(busy2), .BUSYWAIT(bw2), .DONE(done2), .RESULT(res2)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns one negedge after the accept edge
  task automatic launch(input int d, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b);
    sel   = d[1:0];
    go    = 1'b1;
    FUNC3 = f;
    OP1   = a;
    OP2   = b;
    @(negedge CLK);
    go = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] r, output int lat);
    lat = -1;
    r   = '0;
    for (int n = 1; n <= 80; n++) begin
      if (cur_done) begin
        lat = n;
        r   = cur_res;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic do_op(input int d, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat);
    launch(d, f, a, b);
    wait_done(r, lat);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] mask, am, bm;
    logic signed [127:0] sa, sb, ua, ub, p, q, r, mn;
    logic sgn;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am = a & mask;
    bm = b & mask;
    ua = $signed({96'b0, am});
    ub = $signed({96'b0, bm});
    sa = am[w-1] ? ua - (128'sd1 <<< w) : ua;
    sb = bm[w-1] ? ub - (128'sd1 <<< w) : ub;
    mn = -(128'sd1 <<< (w - 1));
    sgn = (f == 3'd4) || (f == 3'd6);
    p = '0;
    case (f)
      3'd0: p = sa * sb;
      3'd1: p = (sa * sb) >>> w;
      3'd2: p = (sa * ub) >>> w;
      3'd3: p = (ua * ub) >>> w;
      default: begin
        if (bm == 0) begin
          q = -128'sd1;
          r = ua;
        end else if (sgn && sa == mn && sb == -128'sd1) begin
          q = sa;
          r = 0;
        end else if (sgn) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = ua / ub;
          r = ua % ub;
        end
        p = (f == 3'd4 || f == 3'd5) ? q : r;
      end
    endcase
    return p[31:0] & mask;
  endfunction

  initial begin
    logic [31:0] r, prev, a, b;
    int lat, cnt, exp_lat;
    logic [2:0] f3;
    logic fix;

    RESET = 1'b0;
    FLUSH = 1'b0;
    go    = 1'b1;
    sel   = 2'd0;
    FUNC3 = 3'd0;
    OP1   = '0;
    OP2   = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_result", res0, 0);
    check("rst_busywait", bw0, 0);
    go    = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);

    do_op(0, 3'd0, 32'hFFFF_FFFF, 32'h2, r, lat);
    check("mul_lat", lat, 2);
    check("mul_res", r, 32'hFFFF_FFFE);
    do_op(0, 3'd3, 32'hFFFF_FFFF, 32'h2, r, lat);
    check("mulhu_res", r, 32'h1);
    do_op(0, 3'd1, 32'hFFFF_FFFF, 32'h2, r, lat);
    check("mulh_res", r, 32'hFFFF_FFFF);
    do_op(0, 3'd2, 32'hFFFF_FFFF, 32'h2, r, lat);
    check("mulhsu_res", r, 32'hFFFF_FFFF);

    do_op(0, 3'd4, 32'hFFFF_FFF9, 32'h2, r, lat);
    check("div_lat", lat, 34);
    check("div_res", r, 32'hFFFF_FFFD);
    do_op(0, 3'd6, 32'hFFFF_FFF9, 32'h2, r, lat);
    check("rem_res", r, 32'hFFFF_FFFF);
    do_op(1, 3'd4, 32'hFFFF_FFF9, 32'h2, r, lat);
    check("div_r2_lat", lat, 18);
    check("div_r2_res", r, 32'hFFFF_FFFD);

    do_op(0, 3'd5, 32'd5, 32'd0, r, lat);
    check("divu0_lat", lat, 2);
    check("divu0_res", r, 32'hFFFF_FFFF);
    do_op(0, 3'd7, 32'd5, 32'd0, r, lat);
    check("remu0_res", r, 32'd5);
    do_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    check("divovf_lat", lat, 2);
    check("divovf_res", r, 32'h8000_0000);
    do_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    check("removf_res", r, 32'h0);

    prev = res0;
    launch(0, 3'd4, 32'd1000, 32'd3);
    repeat (9) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush_busy", busy0, 0);
    check("flush_result", res0, prev);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done0) cnt++;
      @(negedge CLK);
    end
    check("flush_no_done", cnt, 0);

    launch(0, 3'd4, 32'd100, 32'd7);
    repeat (4) @(negedge CLK);
    go    = 1'b1;
    FUNC3 = 3'd0;
    OP1   = 32'd3;
    OP2   = 32'd3;
    @(negedge CLK);
    go = 1'b0;
    check("busywait_div", bw0, 1);
    wait_done(r, lat);
    check("ign_start_lat", lat, 29);
    check("ign_start_res", r, 32'd14);
    go    = 1'b1;
    FUNC3 = 3'd0;
    OP1   = 32'd6;
    OP2   = 32'd7;
    #1;
    check("busywait_done", bw0, 0);
    @(negedge CLK);
    go = 1'b0;
    wait_done(r, lat);
    check("b2b_lat", lat, 2);
    check("b2b_res", r, 32'd42);

    launch(0, 3'd5, 32'd12345, 32'd6);
    repeat (9) @(negedge CLK);
    RESET = 1'b0;
    go    = 1'b1;
    #1;
    check("rst_bw_comb", bw0, 0);
    @(negedge CLK);
    check("rst_mid_outs", {busy0, done0, bw0, res0}, 0);
    go    = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);

    do_op(2, 3'd0, 32'hFFFF, 32'h2, r, lat);
    check("x16_mul", r, 32'hFFFE);
    do_op(2, 3'd3, 32'hFFFF, 32'h2, r, lat);
    check("x16_mulhu", r, 32'h1);
    do_op(2, 3'd1, 32'hFFFF, 32'h2, r, lat);
    check("x16_mulh", r, 32'hFFFF);
    do_op(2, 3'd4, 32'hFFF9, 32'h2, r, lat);
    check("x16_div_lat", lat, 10);
    check("x16_div", r, 32'hFFFD);
    do_op(2, 3'd6, 32'hFFF9, 32'h2, r, lat);
    check("x16_rem", r, 32'hFFFF);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 1000; i++) begin
        f3 = f[2:0];
        a  = $urandom & 32'hFFFF;
        b  = $urandom & 32'hFFFF;
        case ($urandom_range(0, 15))
          0: b = 32'h0;
          1: b = 32'hFFFF;
          2: a = 32'h8000;
          3: begin
            a = 32'h8000;
            b = 32'hFFFF;
          end
          default: ;
        endcase
        fix = (b == 0) || ((f == 4 || f == 6) &&
              a == 32'h8000 && b == 32'hFFFF);
        exp_lat = (f < 4 || fix) ? 2 : 10;
        do_op(2, f3, a, b, r, lat);
        check("x16_rnd_res", r, ref_op(f3, a, b, 16));
        check("x16_rnd_lat", lat, exp_lat);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
